// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//   Shared NoC definitions: default packet layout, VC type and the saturating
//   hop-count decrement applied to every forwarded packet.
//   Layout defaults: DATA_W=64, VC bit 63, hop field [55:48].
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int unsigned NOC_DATA_W  = 64;
  localparam int unsigned NOC_VC_BIT  = 63;
  localparam int unsigned NOC_HOP_LSB = 48;
  localparam int unsigned NOC_HOP_W   = 8;

  typedef logic                  vc_t;
  typedef logic [NOC_DATA_W-1:0] packet_t;

  // Decrement the hop field only; 0 stays 0 and nothing borrows from
  // neighbouring bits.
  function automatic packet_t hop_dec(input packet_t pkt);
    packet_t              res;
    logic [NOC_HOP_W-1:0] hop;
    res = pkt;
    hop = pkt[NOC_HOP_LSB +: NOC_HOP_W];
    if (hop != '0) begin
      res[NOC_HOP_LSB +: NOC_HOP_W] = hop - NOC_HOP_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_rr_arbiter
//   Purely combinational round-robin pick. The pointer register lives in the
//   parent; this block only searches upward from it (wrapping mod NUM_IN).
//   Ports:
//     req      in  NUM_IN   eligible requesters
//     ptr      in  PTR_W    highest-priority requester index
//     grant    out NUM_IN   one-hot grant (all zero when nothing eligible)
//     next_ptr out PTR_W    (granted+1) mod NUM_IN, or ptr when no grant
// ---------------------------------------------------------------------------
module noc_rr_arbiter #(
  parameter int unsigned NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] ptr,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] next_ptr
);

  localparam int unsigned PTR_W = $clog2(NUM_IN);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_IN; off++) begin
      idx = PTR_W'((32'(ptr) + off) % NUM_IN);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((32'(idx) + 32'd1) % NUM_IN);
      end
    end
  end

endmodule

// File: rtl/noc_vc_output_port.sv
// ---------------------------------------------------------------------------
// noc_vc_output_port
//   Router output stage: NUM_IN crossbar requesters are arbitrated round-robin
//   into two single-entry VC buffers. A polarity bit p toggles every cycle;
//   VC ~p accepts a grant while VC p drains downstream over so/ro.
//   Forwarded packets have their hop field decremented (saturating at 0).
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   synchronous, active-low
//     req_valid    in   NUM_IN          requester i holds a packet
//     req_data     in   NUM_IN*DATA_W   packet i at [i*DATA_W +: DATA_W]
//     req_grant    out  NUM_IN          one-hot, combinational; taken at edge
//     so           out  send-out, registered
//     data_out     out  DATA_W          data-out, registered ("do" is a
//                                       reserved word, hence the rename)
//     ro           in   downstream ready, sampled at the edge
//     polarity_out out  current polarity p
//     vc_full      out  2               VC0/VC1 buffer occupancy
// ---------------------------------------------------------------------------
module noc_vc_output_port
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DATA_W  = NOC_DATA_W,
  parameter int unsigned VC_BIT  = NOC_VC_BIT,
  parameter int unsigned HOP_LSB = NOC_HOP_LSB,
  parameter int unsigned HOP_W   = NOC_HOP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req_valid,
  input  logic [NUM_IN*DATA_W-1:0] req_data,
  output logic [NUM_IN-1:0]        req_grant,
  output logic                     so,
  output logic [DATA_W-1:0]        data_out,
  input  logic                     ro,
  output logic                     polarity_out,
  output logic [1:0]               vc_full
);

  localparam int unsigned PTR_W = $clog2(NUM_IN);

  vc_t               polarity;
  vc_t               fill_vc;
  logic [1:0]        vc_full_q;
  logic [DATA_W-1:0] vc_buf [2];
  logic [PTR_W-1:0]  rr_ptr [2];

  logic [NUM_IN-1:0] req_vc_bit;
  logic [NUM_IN-1:0] vc_req      [2];
  logic [NUM_IN-1:0] grant_vc    [2];
  logic [PTR_W-1:0]  next_ptr_vc [2];
  logic [PTR_W-1:0]  fill_next_ptr;
  logic [DATA_W-1:0] fill_pkt;
  logic [DATA_W-1:0] fill_pkt_dec;

  assign fill_vc      = ~polarity;
  assign polarity_out = polarity;
  assign vc_full      = vc_full_q;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_vc_bit
    assign req_vc_bit[i] = req_data[i*DATA_W + VC_BIT];
  end

  // A full buffer blocks further grants on its VC (back-pressure).
  assign vc_req[0] = req_valid & ~req_vc_bit & {NUM_IN{~vc_full_q[0]}};
  assign vc_req[1] = req_valid &  req_vc_bit & {NUM_IN{~vc_full_q[1]}};

  for (genvar v = 0; v < 2; v++) begin : g_arb
    noc_rr_arbiter #(
      .NUM_IN(NUM_IN)
    ) u_arb (
      .req      (vc_req[v]),
      .ptr      (rr_ptr[v]),
      .grant    (grant_vc[v]),
      .next_ptr (next_ptr_vc[v])
    );
  end

  // Only the fill VC's arbiter may grant; the drain VC's result is ignored.
  assign req_grant     = !reset ? '0 : (polarity ? grant_vc[0] : grant_vc[1]);
  assign fill_next_ptr = polarity ? next_ptr_vc[0] : next_ptr_vc[1];

  always_comb begin
    fill_pkt = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (req_grant[i]) begin
        fill_pkt = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  if (DATA_W == NOC_DATA_W && HOP_LSB == NOC_HOP_LSB && HOP_W == NOC_HOP_W) begin : g_pkg_dec
    assign fill_pkt_dec = hop_dec(fill_pkt);
  end else begin : g_local_dec
    logic [HOP_W-1:0] hop;
    assign hop = fill_pkt[HOP_LSB +: HOP_W];
    always_comb begin
      fill_pkt_dec = fill_pkt;
      if (hop != '0) begin
        fill_pkt_dec[HOP_LSB +: HOP_W] = hop - HOP_W'(1);
      end
    end
  end

  // Fill and drain always address different VCs, so their updates never
  // collide on the same buffer or occupancy bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      polarity  <= 1'b0;
      vc_full_q <= '0;
      so        <= 1'b0;
      data_out  <= '0;
      rr_ptr[0] <= '0;
      rr_ptr[1] <= '0;
      vc_buf[0] <= '0;
      vc_buf[1] <= '0;
    end else begin
      polarity <= ~polarity;

      if (|req_grant) begin
        vc_buf[fill_vc]    <= fill_pkt_dec;
        vc_full_q[fill_vc] <= 1'b1;
        rr_ptr[fill_vc]    <= fill_next_ptr;
      end

      if (vc_full_q[polarity] && ro) begin
        so                  <= 1'b1;
        data_out            <= vc_buf[polarity];
        vc_full_q[polarity] <= 1'b0;
      end else begin
        so <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_vc_output_port.sv
// ---------------------------------------------------------------------------
// tb_noc_vc_output_port
//   Directed stimulus; a behavioural port model (queues per requester, two
//   buffer slots, per-VC next-priority index) predicts every output, and a
//   compare process checks the DUT against it each cycle. Literal checks on
//   the model's grant/delivery logs pin the model itself.
// ---------------------------------------------------------------------------
module tb_noc_vc_output_port;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_grant;
  logic            so;
  logic [DW-1:0]   data_out;
  logic            ro = 1'b1;
  logic            polarity_out;
  logic [1:0]      vc_full;

  noc_vc_output_port #(
    .NUM_IN (N),
    .DATA_W (DW),
    .VC_BIT (63),
    .HOP_LSB(48),
    .HOP_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_grant   (req_grant),
    .so          (so),
    .data_out    (data_out),
    .ro          (ro),
    .polarity_out(polarity_out),
    .vc_full     (vc_full)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;
  int ro_mode = 1;   // 0: ro low, 1: ro high, 2: ro high only in p=1 cycles

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; int src; bit vc; } glog_t;
  typedef struct { int cyc; logic [63:0] data; } dlog_t;

  logic [63:0] iq [N][$];
  glog_t       glog[$];
  dlog_t       dlog[$];
  int          cyc = 0;
  bit          mp = 1'b0;
  bit          mfull [2] = '{1'b0, 1'b0};
  logic [63:0] mslot [2] = '{64'd0, 64'd0};
  int          mptr  [2] = '{0, 0};
  bit          mso = 1'b0;
  logic [63:0] mdo = 64'd0;

  function automatic logic [63:0] mdec(input logic [63:0] x);
    int hop;
    hop = int'((x >> 48) & 64'hFF);
    if (hop != 0) return x - (64'd1 << 48);
    return x;
  endfunction

  // Which requester the port must grant in the current cycle (-1: none).
  function automatic int model_grant();
    bit          f;
    int          i;
    logic [63:0] pk;
    f = !mp;
    if (reset !== 1'b1 || mfull[f]) return -1;
    for (int k = 0; k < N; k++) begin
      i  = (mptr[f] + k) % N;
      pk = req_data[i*DW +: DW];
      if (req_valid[i] === 1'b1 && pk[63] == f) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int          g;
    bit          f;
    bit          drain;
    logic [63:0] pk;
    cyc++;
    if (reset !== 1'b1) begin
      mp = 1'b0; mfull = '{1'b0, 1'b0}; mso = 1'b0; mdo = 64'd0; mptr = '{0, 0};
    end else begin
      g     = model_grant();
      f     = !mp;
      drain = mfull[mp] && (ro === 1'b1);
      if (g >= 0) begin
        pk       = req_data[g*DW +: DW];
        mslot[f] = mdec(pk);
        mfull[f] = 1'b1;
        mptr[f]  = (g + 1) % N;
        glog.push_back('{cyc, g, f});
        void'(iq[g].pop_front());
      end
      if (drain) begin
        mso       = 1'b1;
        mdo       = mslot[mp];
        mfull[mp] = 1'b0;
        dlog.push_back('{cyc, mdo});
      end else begin
        mso = 1'b0;
      end
      mp = !mp;
    end
  end

  // ---------------- requester / downstream driver ----------------
  always @(negedge clk) begin
    #1;
    ro = (ro_mode == 1) || (ro_mode == 2 && mp);
    for (int i = 0; i < N; i++) begin
      if (iq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = iq[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int          g;
    logic [N-1:0] eg;
    #3;
    if (started) begin
      g  = model_grant();
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("req_grant", 64'(req_grant), 64'(eg));
      chk("so", 64'(so), 64'(mso));
      chk("data_out", data_out, mdo);
      chk("polarity_out", 64'(polarity_out), 64'(mp));
      chk("vc_full", 64'(vc_full), {62'd0, mfull[1], mfull[0]});
    end
  end

  // ---------------- helpers ----------------
  task automatic push(input int i, input logic [63:0] pkt);
    iq[i].push_back(pkt);
  endtask

  task automatic clear_logs();
    glog.delete();
    dlog.delete();
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (iq[i].size() > 0) return 1'b1;
    return mfull[0] || mfull[1];
  endfunction

  task automatic wait_done(input string name, input int max);
    int k = 0;
    while (busy() && k < max) begin
      @(negedge clk);
      k++;
    end
    if (k >= max) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, max);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic int count_data(input logic [63:0] x);
    int c = 0;
    foreach (dlog[j]) if (dlog[j].data == x) c++;
    return c;
  endfunction

  logic [63:0] t3_in  [4] = '{64'h0005_0000_00AB_CDEF, 64'h0005_0000_1234_5678,
                              64'h0005_0000_00DE_F123, 64'h0005_0000_0001_1A11};
  logic [63:0] t3_out [4] = '{64'h0004_0000_00AB_CDEF, 64'h0004_0000_1234_5678,
                              64'h0004_0000_00DE_F123, 64'h0004_0000_0001_1A11};

  initial begin
    int k;
    int n0;
    int nvc0;

    repeat (3) @(negedge clk);
    started = 1'b1;
    reset   = 1'b1;

    // 1: single VC0 packet
    clear_logs();
    push(0, 64'h0002_0000_0000_FA50);
    wait_done("t1", 40);
    chk("t1_grants", 64'(glog.size()), 64'd1);
    chk("t1_sends", 64'(dlog.size()), 64'd1);
    if (glog.size() >= 1 && dlog.size() >= 1) begin
      chk("t1_src", 64'(glog[0].src), 64'd0);
      chk("t1_vc", 64'(glog[0].vc), 64'd0);
      chk("t1_data", dlog[0].data, 64'h0001_0000_0000_FA50);
      chk("t1_latency", 64'(dlog[0].cyc - glog[0].cyc), 64'd1);
    end

    // 2: VC1 and VC0 packets in the same cycle
    clear_logs();
    push(1, 64'h8010_0000_0000_C7D4);
    push(2, 64'h0010_0000_0000_6840);
    wait_done("t2", 40);
    chk("t2_sends", 64'(dlog.size()), 64'd2);
    if (dlog.size() == 2) begin
      chk("t2_consecutive", 64'(dlog[1].cyc - dlog[0].cyc), 64'd1);
      chk("t2_vc1_pkt", 64'(count_data(64'h800F_0000_0000_C7D4)), 64'd1);
      chk("t2_vc0_pkt", 64'(count_data(64'h000F_0000_0000_6840)), 64'd1);
    end

    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 3: four VC0 contenders served 0,1,2,3, one per 2 cycles
    clear_logs();
    for (int i = 0; i < 4; i++) push(i, t3_in[i]);
    wait_done("t3", 80);
    chk("t3_grants", 64'(glog.size()), 64'd4);
    chk("t3_sends", 64'(dlog.size()), 64'd4);
    if (glog.size() == 4 && dlog.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("t3_order", 64'(glog[j].src), 64'(j));
        chk("t3_data", dlog[j].data, t3_out[j]);
        if (j > 0) begin
          chk("t3_grant_gap", 64'(glog[j].cyc - glog[j-1].cyc), 64'd2);
          chk("t3_so_gap", 64'(dlog[j].cyc - dlog[j-1].cyc), 64'd2);
        end
      end
    end
    chk("t3_ptr_wrap", 64'(mptr[0]), 64'd0);

    // 4: VC0 back-pressured while VC1 keeps flowing
    clear_logs();
    ro_mode = 2;
    push(0, 64'h0003_0000_0000_0A0A);
    k = 0;
    while (!mfull[0] && k < 20) begin @(negedge clk); k++; end
    chk("t4_vc0_filled", 64'(mfull[0]), 64'd1);
    push(1, 64'h0003_0000_0000_0B0B);
    push(2, 64'h8003_0000_0000_0C0C);
    push(3, 64'h8003_0000_0000_0D0D);
    repeat (10) @(negedge clk);
    chk("t4_vc0_held", 64'(mfull[0]), 64'd1);
    nvc0 = 0;
    foreach (glog[j]) if (glog[j].vc == 1'b0) nvc0++;
    chk("t4_no_vc0_grant", 64'(nvc0), 64'd1);
    chk("t4_vc1_sends", 64'(dlog.size()), 64'd2);
    chk("t4_vc1_c", 64'(count_data(64'h8002_0000_0000_0C0C)), 64'd1);
    chk("t4_vc1_d", 64'(count_data(64'h8002_0000_0000_0D0D)), 64'd1);
    n0 = dlog.size();
    ro_mode = 1;
    wait_done("t4", 40);
    chk("t4_after_release", 64'(dlog.size() - n0), 64'd2);
    if (dlog.size() == n0 + 2) begin
      chk("t4_first_released", dlog[n0].data, 64'h0002_0000_0000_0A0A);
      chk("t4_second_released", dlog[n0+1].data, 64'h0002_0000_0000_0B0B);
    end

    // 5: hop saturation and field isolation
    clear_logs();
    push(1, 64'h8000_1234_5678_9ABC);
    push(2, 64'h01FF_0000_0000_0001);
    push(3, 64'h7E01_FFFF_FFFF_FFFF);
    wait_done("t5", 40);
    chk("t5_sends", 64'(dlog.size()), 64'd3);
    chk("t5_hop00", 64'(count_data(64'h8000_1234_5678_9ABC)), 64'd1);
    chk("t5_hopFF", 64'(count_data(64'h01FE_0000_0000_0001)), 64'd1);
    chk("t5_hop01", 64'(count_data(64'h7E00_FFFF_FFFF_FFFF)), 64'd1);

    // 6: reset with both VCs full
    clear_logs();
    ro_mode = 0;
    push(0, 64'h0004_0000_0000_0606);
    push(1, 64'h8004_0000_0000_1616);
    k = 0;
    while (!(mfull[0] && mfull[1]) && k < 20) begin @(negedge clk); k++; end
    chk("t6_both_full", {62'd0, mfull[1], mfull[0]}, 64'd3);
    push(2, 64'h0004_0000_0000_2626);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_reset_full", {62'd0, mfull[1], mfull[0]}, 64'd0);
    chk("t6_reset_pol", 64'(mp), 64'd0);
    chk("t6_no_send", 64'(dlog.size()), 64'd0);
    reset   = 1'b1;
    ro_mode = 1;
    push(0, 64'h0004_0000_0000_0606);
    push(1, 64'h8004_0000_0000_1616);
    wait_done("t6", 60);
    chk("t6_sends", 64'(dlog.size()), 64'd3);
    chk("t6_pkt_a", 64'(count_data(64'h0003_0000_0000_0606)), 64'd1);
    chk("t6_pkt_b", 64'(count_data(64'h8003_0000_0000_1616)), 64'd1);
    chk("t6_pkt_c", 64'(count_data(64'h0003_0000_0000_2626)), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
